// File: rtl/memory_stage.sv
// memory_stage: EM->MW stage with a stalling data-memory handshake, timeout error halt and dump halt.
module memory_stage #(
  parameter int TIMEOUT_CYCLES = 15
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] inc_PC_in,
  input  logic [15:0] imm_2_in,
  input  logic [15:0] read_data_2_in,
  input  logic [15:0] ALU_result_in,
  input  logic        dump_in,
  input  logic        mem_write_en_in,
  input  logic        mem_enable_in,
  input  logic        reg_write_en_in,
  input  logic [1:0]  reg_src_in,
  input  logic [2:0]  write_reg_sel_in,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [15:0] dmem_addr,
  output logic [15:0] dmem_wdata,
  input  logic        dmem_ready,
  input  logic [15:0] dmem_rdata,
  output logic        stall_out,
  output logic [15:0] wb_data_MW_out,
  output logic        reg_write_en_MW_out,
  output logic [2:0]  write_reg_sel_MW_out,
  output logic        halt_out,
  output logic        err_out
);
  typedef enum logic [1:0] {IDLE, WAIT, HALT} state_t;
  state_t state, state_nx;
  logic [7:0] cnt, cnt_nx;
  logic done, timeout;
  logic [15:0] wb_sel;
  assign dmem_req   = rst & mem_enable_in & (state != HALT);
  assign dmem_we    = mem_write_en_in & dmem_req;
  assign dmem_addr  = ALU_result_in;
  assign dmem_wdata = read_data_2_in;
  // an instruction completes when it needs no memory or the memory answers
  assign done    = (state == IDLE) ? (~mem_enable_in | dmem_ready) : (state == WAIT) & dmem_ready;
  assign timeout = (state == WAIT) & ~dmem_ready & (cnt == 8'(TIMEOUT_CYCLES));
  assign stall_out = rst & ~done;
  assign wb_sel = reg_src_in[1] ? (reg_src_in[0] ? imm_2_in : inc_PC_in)
                                : (reg_src_in[0] ? dmem_rdata : ALU_result_in);
  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    if (done) begin
      state_nx = dump_in ? HALT : IDLE;
      cnt_nx   = 8'd0;
    end else if (state == IDLE) begin
      state_nx = WAIT;
      cnt_nx   = 8'd1;
    end else if (state == WAIT) begin
      state_nx = timeout ? HALT : WAIT;
      cnt_nx   = timeout ? cnt : cnt + 8'd1;
    end
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state                <= IDLE;
      cnt                  <= 8'd0;
      wb_data_MW_out       <= 16'd0;
      reg_write_en_MW_out  <= 1'b0;
      write_reg_sel_MW_out <= 3'd0;
      halt_out             <= 1'b0;
      err_out              <= 1'b0;
    end else begin
      state               <= state_nx;
      cnt                 <= cnt_nx;
      reg_write_en_MW_out <= done & reg_write_en_in;
      if (done) begin
        wb_data_MW_out       <= wb_sel;
        write_reg_sel_MW_out <= write_reg_sel_in;
      end
      halt_out <= halt_out | (state_nx == HALT);
      err_out  <= err_out | timeout;
    end
  end
endmodule
